// File: rtl/serial_rx8.sv
// serial_rx8: samples an async serial line and assembles 8-bit frames
//   (start 0, 8 data bits LSB first, optional even parity, stop 1).
// Latency: data_valid / frame_err / parity_err pulse one Clk after the stop-bit mid sample.
// Backpressure: none; every data_valid pulse must be captured by the downstream register.
// Optional even-parity bit is compiled in with `define SERIAL_RX8_PARITY_EN.
module serial_rx8 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       Clk,
  input  logic       Res,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  // First wait lands on the middle of the start bit, later waits are one full bit.
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

`ifdef SERIAL_RX8_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;
`endif

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data_out;
  logic            r_data_valid;
  logic            r_frame_err;
  logic            r_busy;
`ifdef SERIAL_RX8_PARITY_EN
  logic            r_par_acc;     // running XOR of data bits
  logic            r_par_bad;     // parity sample disagreed with even parity
  logic            r_parity_err;
`endif

  logic            w_rx_s;
  logic            w_tmr_done;

  // Two-flop synchronizer; resets to the idle-high line level so reset release is not a start edge.
  always_ff @(posedge Clk or posedge Res) begin
    if (Res) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s     = r_sync2;
  assign w_tmr_done = (r_timer == '0);

  // Receive FSM: bit timing, byte assembly and registered result pulses.
  always_ff @(posedge Clk or posedge Res) begin
    if (Res) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
      r_par_acc    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // Result outputs are single-cycle pulses unless re-asserted below.
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_timer <= HALF_M1;
            r_busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (w_tmr_done) begin
            if (w_rx_s) begin
              // Line went back high before mid start bit: treat as a glitch.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
              r_idx   <= 3'd0;
              r_timer <= FULL_M1;
`ifdef SERIAL_RX8_PARITY_EN
              r_par_acc <= 1'b0;
              r_par_bad <= 1'b0;
`endif
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        ST_DATA: begin
          if (w_tmr_done) begin
            r_shift[r_idx] <= w_rx_s;
            r_timer        <= FULL_M1;
`ifdef SERIAL_RX8_PARITY_EN
            r_par_acc      <= r_par_acc ^ w_rx_s;
`endif
            if (r_idx == 3'd7) begin
`ifdef SERIAL_RX8_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

`ifdef SERIAL_RX8_PARITY_EN
        ST_PARITY: begin
          if (w_tmr_done) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            r_par_bad <= r_par_acc ^ w_rx_s;
            r_state   <= ST_STOP;
            r_timer   <= FULL_M1;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
`endif

        ST_STOP: begin
          if (w_tmr_done) begin
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
              end
`else
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
`endif
            end else begin
              // Bad stop bit wins over parity; hold the last good byte.
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low (break) line must return high before a new start is accepted.
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
`ifdef SERIAL_RX8_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx8.sv
// tb_serial_rx8: drives serial frames into serial_rx8 and scoreboards the received bytes.
// Expected bytes are queued as each frame is driven and popped on every data_valid pulse.
// Error pulses, pulse widths, busy and output latency are checked against bench-side counts.
`timescale 1ns/1ps
module tb_serial_rx8;

  localparam int CPB = 16;
`ifdef SERIAL_RX8_PARITY_EN
  localparam int NPRE = 10;   // start + 8 data + parity before the stop bit
`else
  localparam int NPRE = 9;    // start + 8 data before the stop bit
`endif
  // From driving the start edge: 2 sync flops, mid stop bit, then the registered pulse.
  localparam int RES_LAT = NPRE * CPB + CPB / 2 + 3;

  logic       Clk = 1'b0;
  logic       Res;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int cyc = 0;
  int start_cyc = 0;
  int last_dv_cyc = 0;
  int last_ferr_cyc = 0;
  int n_dv = 0, n_ferr = 0, n_perr = 0;
  int exp_dv = 0, exp_ferr = 0, exp_perr = 0;
  logic prev_dv = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  logic [7:0] sb_b;
  logic       sb_have;

  serial_rx8 #(.CLKS_PER_BIT(CPB)) dut (
    .Clk        (Clk),
    .Res        (Res),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Drives one frame; the line is left at the stop-bit level for the caller to release.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic chk_busy);
    logic par_ok;
`ifdef SERIAL_RX8_PARITY_EN
    par_ok = ~((^d) ^ par_b);
`else
    par_ok = 1'b1 | par_b;   // parity bit is not transmitted in this build
`endif
    if (!stop_b)      exp_ferr++;
    else if (!par_ok) exp_perr++;
    else begin
      exp_q.push_back(d);
      exp_dv++;
    end
    start_cyc = cyc;
    rx_in = 1'b0;
    tick(2);
    if (chk_busy) chk("busy_at_T0", busy, 1'b0);
    tick(1);
    if (chk_busy) chk("busy_after_T0", busy, 1'b1);
    tick(CPB - 3);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(CPB);
    end
`ifdef SERIAL_RX8_PARITY_EN
    rx_in = par_b;
    tick(CPB);
`endif
    rx_in = stop_b;
    tick(CPB);
  endtask

  // Output monitor: scoreboard pops on data_valid, pulse width and hold checks.
  always @(negedge Clk) begin
    if (!Res) begin
      if (data_valid) begin
        n_dv++;
        last_dv_cyc = cyc;
        chk("dv_one_cycle", prev_dv, 1'b0);
        chk("busy_low_at_dv", busy, 1'b0);
        sb_have = (exp_q.size() > 0);
        sb_b    = sb_have ? exp_q.pop_front() : 8'h00;
        chk("data_out_sb", {1'b1, data_out}, {sb_have, sb_b});
      end else begin
        chk("data_out_hold", data_out, prev_dout);
      end
      if (frame_err) begin
        n_ferr++;
        last_ferr_cyc = cyc;
        chk("ferr_one_cycle", prev_ferr, 1'b0);
        chk("dv_with_ferr", data_valid, 1'b0);
      end
      if (parity_err) begin
        n_perr++;
        chk("perr_one_cycle", prev_perr, 1'b0);
        chk("dv_with_perr", data_valid, 1'b0);
      end
    end
    prev_dv   = data_valid;
    prev_ferr = frame_err;
    prev_perr = parity_err;
    prev_dout = data_out;
  end

  initial begin
    Res   = 1'b0;
    rx_in = 1'b1;
    #1 Res = 1'b1;
    #2;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    #20 Res = 1'b0;
    tick(1);
    chk("busy_after_rst", busy, 1'b0);
    tick(4);

    // Plain frame 0xA5 with latency check.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    rx_in = 1'b1;
    chk("dv_latency", last_dv_cyc - start_cyc, RES_LAT);
    chk("data_out_A5", data_out, 8'hA5);
    chk("busy_idle_A5", busy, 1'b0);
    tick(5);

    // Four-cycle low glitch on an idle line.
    rx_in = 1'b0;
    tick(3);
    chk("glitch_busy_start", busy, 1'b1);
    tick(1);
    rx_in = 1'b1;
    tick(6);
    chk("glitch_busy_mid", busy, 1'b1);
    tick(2);
    chk("glitch_idle", busy, 1'b0);
    tick(20);
    chk("glitch_data_out", data_out, 8'hA5);
    chk("glitch_dv_count", n_dv, 1);

    // 0x3C with a bad stop bit, then the line held low.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(40);
    chk("ferr_latency", last_ferr_cyc - start_cyc, RES_LAT);
    chk("ferr_count", n_ferr, 1);
    chk("wait_high_busy", busy, 1'b1);
    rx_in = 1'b1;
    tick(4);
    chk("wait_high_release", busy, 1'b0);
    chk("ferr_data_out", data_out, 8'hA5);
    tick(30);

    // Back-to-back frames.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 1'b0);
    rx_in = 1'b1;
    tick(10);
    chk("b2b_data_out", data_out, 8'h80);
    chk("b2b_dv_count", n_dv, 3);

    // Reset in the middle of data bit 4 of 0xFF.
    rx_in = 1'b0;
    tick(CPB);
    rx_in = 1'b1;
    tick(CPB * 4 + CPB / 2);
    #3 Res = 1'b1;
    #1;
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dv", data_valid, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    #3 Res = 1'b0;
    tick(1);
    chk("busy_after_midrst", busy, 1'b0);
    tick(3);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    rx_in = 1'b1;
    tick(10);
    chk("post_rst_data_out", data_out, 8'h12);

`ifdef SERIAL_RX8_PARITY_EN
    // 0x03 has two ones: parity bit 1 is wrong, parity bit 0 is right.
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    rx_in = 1'b1;
    tick(10);
    chk("perr_count", n_perr, 1);
    chk("perr_data_out", data_out, 8'h12);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    rx_in = 1'b1;
    tick(10);
    chk("par_ok_data_out", data_out, 8'h03);
`endif

    tick(20);
    chk("sb_empty", exp_q.size(), 0);
    chk("dv_total", n_dv, exp_dv);
    chk("ferr_total", n_ferr, exp_ferr);
    chk("perr_total", n_perr, exp_perr);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
